// File: rtl/pipe_defs.sv
// Shared pipeline definitions: opcode/ALU/branch encodings, the decode control
// bundle carried into EXE, and the MUL sequencer state type.
package pipe_defs;

    localparam int OP_W_DEFAULT  = 6;
    localparam int EXE_W_DEFAULT = 4;

    localparam logic [5:0] OP_NOP  = 6'd0;
    localparam logic [5:0] OP_ADD  = 6'd1;
    localparam logic [5:0] OP_SUB  = 6'd3;
    localparam logic [5:0] OP_AND  = 6'd5;
    localparam logic [5:0] OP_OR   = 6'd6;
    localparam logic [5:0] OP_NOR  = 6'd7;
    localparam logic [5:0] OP_XOR  = 6'd8;
    localparam logic [5:0] OP_SLA  = 6'd9;
    localparam logic [5:0] OP_SLL  = 6'd10;
    localparam logic [5:0] OP_SRA  = 6'd11;
    localparam logic [5:0] OP_SRL  = 6'd12;
    localparam logic [5:0] OP_MUL  = 6'd13;
    localparam logic [5:0] OP_ADDI = 6'd32;
    localparam logic [5:0] OP_SUBI = 6'd33;
    localparam logic [5:0] OP_LD   = 6'd36;
    localparam logic [5:0] OP_ST   = 6'd37;
    localparam logic [5:0] OP_BEZ  = 6'd40;
    localparam logic [5:0] OP_BNE  = 6'd41;
    localparam logic [5:0] OP_JMP  = 6'd42;

    localparam logic [3:0] EXE_ADD = 4'd0;
    localparam logic [3:0] EXE_SUB = 4'd2;
    localparam logic [3:0] EXE_AND = 4'd4;
    localparam logic [3:0] EXE_OR  = 4'd5;
    localparam logic [3:0] EXE_NOR = 4'd6;
    localparam logic [3:0] EXE_XOR = 4'd7;
    localparam logic [3:0] EXE_SLA = 4'd8;
    localparam logic [3:0] EXE_SLL = 4'd8;
    localparam logic [3:0] EXE_SRA = 4'd9;
    localparam logic [3:0] EXE_SRL = 4'd10;
    localparam logic [3:0] EXE_MUL = 4'd12;
    localparam logic [3:0] EXE_NOP = 4'd15;

    localparam logic [1:0] COND_BEZ  = 2'd0;
    localparam logic [1:0] COND_BNE  = 2'd1;
    localparam logic [1:0] COND_JUMP = 2'd2;

    typedef struct packed {
        logic [EXE_W_DEFAULT-1:0] exe_cmd;
        logic [1:0]               branch_cmd;
        logic                     branch_en;
        logic                     is_imm;
        logic                     st_or_bne;
        logic                     wb_en;
        logic                     mem_r_en;
        logic                     mem_w_en;
    } ctrl_bundle_t;

    typedef enum logic {
        MUL_IDLE,
        MUL_BUSY
    } mul_state_t;

endpackage

// File: rtl/id_ctrl_decode.sv
// Combinational opcode decoder producing the EXE/MEM/WB control bundle and an
// illegal flag; extended ops become illegal when EXT_EN is 0.
module id_ctrl_decode
    import pipe_defs::*;
#(
    parameter int OP_W   = OP_W_DEFAULT,
    parameter bit EXT_EN = 1'b1
) (
    input  logic [OP_W-1:0] i_op_code,
    output ctrl_bundle_t    o_bundle,
    output logic            o_illegal
);

    logic w_ext;

    always_comb begin
        o_bundle  = '0;
        o_illegal = 1'b0;
        w_ext     = 1'b0;
        case (i_op_code)
            OP_W'(OP_NOP):  ;
            OP_W'(OP_ADD):  begin o_bundle.exe_cmd = EXE_ADD; o_bundle.wb_en = 1'b1; end
            OP_W'(OP_SUB):  begin o_bundle.exe_cmd = EXE_SUB; o_bundle.wb_en = 1'b1; end
            OP_W'(OP_AND):  begin o_bundle.exe_cmd = EXE_AND; o_bundle.wb_en = 1'b1; end
            OP_W'(OP_OR):   begin o_bundle.exe_cmd = EXE_OR;  o_bundle.wb_en = 1'b1; w_ext = 1'b1; end
            OP_W'(OP_NOR):  begin o_bundle.exe_cmd = EXE_NOR; o_bundle.wb_en = 1'b1; w_ext = 1'b1; end
            OP_W'(OP_XOR):  begin o_bundle.exe_cmd = EXE_XOR; o_bundle.wb_en = 1'b1; w_ext = 1'b1; end
            OP_W'(OP_SLA):  begin o_bundle.exe_cmd = EXE_SLA; o_bundle.wb_en = 1'b1; w_ext = 1'b1; end
            OP_W'(OP_SLL):  begin o_bundle.exe_cmd = EXE_SLL; o_bundle.wb_en = 1'b1; end
            OP_W'(OP_SRA):  begin o_bundle.exe_cmd = EXE_SRA; o_bundle.wb_en = 1'b1; w_ext = 1'b1; end
            OP_W'(OP_SRL):  begin o_bundle.exe_cmd = EXE_SRL; o_bundle.wb_en = 1'b1; w_ext = 1'b1; end
            OP_W'(OP_MUL):  begin o_bundle.exe_cmd = EXE_MUL; o_bundle.wb_en = 1'b1; end
            OP_W'(OP_ADDI): begin
                o_bundle.exe_cmd = EXE_ADD; o_bundle.wb_en = 1'b1; o_bundle.is_imm = 1'b1;
            end
            OP_W'(OP_SUBI): begin
                o_bundle.exe_cmd = EXE_SUB; o_bundle.wb_en = 1'b1; o_bundle.is_imm = 1'b1;
                w_ext = 1'b1;
            end
            OP_W'(OP_LD): begin
                o_bundle.exe_cmd   = EXE_ADD;
                o_bundle.wb_en     = 1'b1;
                o_bundle.is_imm    = 1'b1;
                o_bundle.st_or_bne = 1'b1;
                o_bundle.mem_r_en  = 1'b1;
            end
            OP_W'(OP_ST): begin
                o_bundle.exe_cmd   = EXE_ADD;
                o_bundle.is_imm    = 1'b1;
                o_bundle.st_or_bne = 1'b1;
                o_bundle.mem_w_en  = 1'b1;
            end
            OP_W'(OP_BNE): begin
                o_bundle.exe_cmd    = EXE_NOP;
                o_bundle.is_imm     = 1'b1;
                o_bundle.st_or_bne  = 1'b1;
                o_bundle.branch_en  = 1'b1;
                o_bundle.branch_cmd = COND_BNE;
            end
            OP_W'(OP_BEZ): begin
                o_bundle.exe_cmd    = EXE_NOP;
                o_bundle.is_imm     = 1'b1;
                o_bundle.branch_en  = 1'b1;
                o_bundle.branch_cmd = COND_BEZ;
                w_ext               = 1'b1;
            end
            OP_W'(OP_JMP): begin
                o_bundle.exe_cmd    = EXE_NOP;
                o_bundle.is_imm     = 1'b1;
                o_bundle.branch_en  = 1'b1;
                o_bundle.branch_cmd = COND_JUMP;
                w_ext               = 1'b1;
            end
            default: o_illegal = 1'b1;
        endcase
        if (w_ext && !EXT_EN) begin
            o_bundle  = '0;
            o_illegal = 1'b1;
        end
    end

endmodule

// File: rtl/id_ctrl_stage.sv
// Decode-stage controller: registers the decoded bundle into ID/EXE, inserts
// bubbles on flush/hazard/illegal, and holds EXE while a multi-cycle MUL runs.
module id_ctrl_stage
    import pipe_defs::*;
#(
    parameter int OP_W       = OP_W_DEFAULT,
    parameter int EXE_W      = EXE_W_DEFAULT,
    parameter int MUL_CYCLES = 4,
    parameter bit EXT_EN     = 1'b1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [OP_W-1:0]  i_op_code,
    input  logic             i_instr_valid,
    input  logic             i_hazard_detected,
    input  logic             i_flush,
    output logic             o_ex_valid,
    output logic [EXE_W-1:0] o_ex_exe_cmd,
    output logic [1:0]       o_ex_branch_cmd,
    output logic             o_ex_branch_en,
    output logic             o_ex_is_imm,
    output logic             o_ex_st_or_bne,
    output logic             o_ex_wb_en,
    output logic             o_ex_mem_r_en,
    output logic             o_ex_mem_w_en,
    output logic             o_stall_req,
    output logic             o_illegal_op
);

    localparam logic [3:0] CNT_LOAD = 4'(MUL_CYCLES - 1);

    ctrl_bundle_t w_dec_bundle;
    logic         w_dec_illegal;
    logic         w_is_mul;

    mul_state_t   r_state, w_state_nxt;
    logic [3:0]   r_cnt, w_cnt_nxt;
    logic         r_valid, w_valid_nxt;
    ctrl_bundle_t r_bundle, w_bundle_nxt;
    logic         r_illegal, w_illegal_nxt;

    id_ctrl_decode #(
        .OP_W   (OP_W),
        .EXT_EN (EXT_EN)
    ) u_decode (
        .i_op_code (i_op_code),
        .o_bundle  (w_dec_bundle),
        .o_illegal (w_dec_illegal)
    );

    assign w_is_mul = (i_op_code == OP_W'(OP_MUL));

    // Priority: flush, MUL hold, hazard, empty slot, illegal, then normal load.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_valid_nxt   = 1'b0;
        w_bundle_nxt  = '0;
        w_illegal_nxt = 1'b0;
        if (i_flush) begin
            w_state_nxt = MUL_IDLE;
            w_cnt_nxt   = 4'd0;
        end else if (r_state == MUL_BUSY) begin
            w_valid_nxt  = r_valid;
            w_bundle_nxt = r_bundle;
            if (r_cnt == 4'd1) begin
                w_state_nxt = MUL_IDLE;
                w_cnt_nxt   = 4'd0;
            end else begin
                w_cnt_nxt = r_cnt - 4'd1;
            end
        end else if (i_hazard_detected || !i_instr_valid) begin
            w_valid_nxt = 1'b0;
        end else if (w_dec_illegal) begin
            w_illegal_nxt = 1'b1;
        end else begin
            w_valid_nxt  = 1'b1;
            w_bundle_nxt = w_dec_bundle;
            if (w_is_mul && (MUL_CYCLES > 1)) begin
                w_state_nxt = MUL_BUSY;
                w_cnt_nxt   = CNT_LOAD;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= MUL_IDLE;
            r_cnt     <= 4'd0;
            r_valid   <= 1'b0;
            r_bundle  <= '0;
            r_illegal <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_valid   <= w_valid_nxt;
            r_bundle  <= w_bundle_nxt;
            r_illegal <= w_illegal_nxt;
        end
    end

    assign o_ex_valid      = r_valid;
    assign o_ex_exe_cmd    = EXE_W'(r_bundle.exe_cmd);
    assign o_ex_branch_cmd = r_bundle.branch_cmd;
    assign o_ex_branch_en  = r_bundle.branch_en;
    assign o_ex_is_imm     = r_bundle.is_imm;
    assign o_ex_st_or_bne  = r_bundle.st_or_bne;
    assign o_ex_wb_en      = r_bundle.wb_en;
    assign o_ex_mem_r_en   = r_bundle.mem_r_en;
    assign o_ex_mem_w_en   = r_bundle.mem_w_en;
    assign o_stall_req     = (r_state == MUL_BUSY);
    assign o_illegal_op    = r_illegal;

endmodule

// File: tb/tb_id_ctrl_stage.sv
// Directed testbench for id_ctrl_stage: one instance with extended ops enabled
// and MUL_CYCLES=4, a second with EXT_EN=0 fed the same stimulus.
module tb_id_ctrl_stage;

    logic       clk;
    logic       rst_n;
    logic [5:0] op;
    logic       valid;
    logic       haz;
    logic       flush;

    logic       a_valid, a_br_en, a_imm, a_sob, a_wb, a_mr, a_mw, a_stall, a_ill;
    logic [3:0] a_exe;
    logic [1:0] a_br;
    logic       b_valid, b_br_en, b_imm, b_sob, b_wb, b_mr, b_mw, b_stall, b_ill;
    logic [3:0] b_exe;
    logic [1:0] b_br;

    logic [14:0] obs;
    logic [14:0] obs0;

    int total = 0;
    int bad   = 0;

    id_ctrl_stage #(.OP_W(6), .EXE_W(4), .MUL_CYCLES(4), .EXT_EN(1'b1)) dut (
        .i_clk (clk), .i_rst_n (rst_n), .i_op_code (op), .i_instr_valid (valid),
        .i_hazard_detected (haz), .i_flush (flush),
        .o_ex_valid (a_valid), .o_ex_exe_cmd (a_exe), .o_ex_branch_cmd (a_br),
        .o_ex_branch_en (a_br_en), .o_ex_is_imm (a_imm), .o_ex_st_or_bne (a_sob),
        .o_ex_wb_en (a_wb), .o_ex_mem_r_en (a_mr), .o_ex_mem_w_en (a_mw),
        .o_stall_req (a_stall), .o_illegal_op (a_ill)
    );

    id_ctrl_stage #(.OP_W(6), .EXE_W(4), .MUL_CYCLES(4), .EXT_EN(1'b0)) dut_noext (
        .i_clk (clk), .i_rst_n (rst_n), .i_op_code (op), .i_instr_valid (valid),
        .i_hazard_detected (haz), .i_flush (flush),
        .o_ex_valid (b_valid), .o_ex_exe_cmd (b_exe), .o_ex_branch_cmd (b_br),
        .o_ex_branch_en (b_br_en), .o_ex_is_imm (b_imm), .o_ex_st_or_bne (b_sob),
        .o_ex_wb_en (b_wb), .o_ex_mem_r_en (b_mr), .o_ex_mem_w_en (b_mw),
        .o_stall_req (b_stall), .o_illegal_op (b_ill)
    );

    // Packed view: {valid, exe[3:0], br[1:0], br_en, imm, st_or_bne, wb, mem_r, mem_w, stall, illegal}
    assign obs  = {a_valid, a_exe, a_br, a_br_en, a_imm, a_sob, a_wb, a_mr, a_mw, a_stall, a_ill};
    assign obs0 = {b_valid, b_exe, b_br, b_br_en, b_imm, b_sob, b_wb, b_mr, b_mw, b_stall, b_ill};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [14:0] expv(input logic v, input logic [3:0] e, input logic [1:0] b,
                                         input logic [5:0] c, input logic s, input logic i);
        return {v, e, b, c, s, i};
    endfunction

    // Drive one ID cycle, then sample 1ns after the capturing edge.
    task automatic applyStimulus(input logic [5:0] o, input logic v, input logic h, input logic f);
        op    = o;
        valid = v;
        haz   = h;
        flush = f;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [14:0] e;
        rst_n = 1'b0;
        op = 6'd0; valid = 1'b0; haz = 1'b0; flush = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (obs !== 15'd0) begin
            bad++; $display("[TB] FAIL reset_state got=%h exp=%h", obs, 15'd0);
        end
        rst_n = 1'b1;
        applyStimulus(6'd13, 1'b1, 1'b0, 1'b0);
        e = expv(1'b1, 4'd12, 2'd0, 6'b000100, 1'b1, 1'b0);
        total++;
        if (obs !== e) begin
            bad++; $display("[TB] FAIL mul_before_reset got=%h exp=%h", obs, e);
        end
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (obs !== 15'd0) begin
            bad++; $display("[TB] FAIL async_reset_mid_mul got=%h exp=%h", obs, 15'd0);
        end
        #2;
        rst_n = 1'b1;
        applyStimulus(6'd1, 1'b1, 1'b0, 1'b0);
        e = expv(1'b1, 4'd0, 2'd0, 6'b000100, 1'b0, 1'b0);
        total++;
        if (obs !== e) begin
            bad++; $display("[TB] FAIL add_after_reset got=%h exp=%h", obs, e);
        end
    endtask

    task automatic test_back_to_back();
        logic [14:0] e;
        applyStimulus(6'd36, 1'b1, 1'b0, 1'b0);
        e = expv(1'b1, 4'd0, 2'd0, 6'b011110, 1'b0, 1'b0);
        total++;
        if (obs !== e) begin
            bad++; $display("[TB] FAIL ld got=%h exp=%h", obs, e);
        end
        applyStimulus(6'd37, 1'b1, 1'b0, 1'b0);
        e = expv(1'b1, 4'd0, 2'd0, 6'b011001, 1'b0, 1'b0);
        total++;
        if (obs !== e) begin
            bad++; $display("[TB] FAIL st got=%h exp=%h", obs, e);
        end
        applyStimulus(6'd0, 1'b1, 1'b0, 1'b0);
        e = expv(1'b1, 4'd0, 2'd0, 6'b000000, 1'b0, 1'b0);
        total++;
        if (obs !== e) begin
            bad++; $display("[TB] FAIL nop got=%h exp=%h", obs, e);
        end
        applyStimulus(6'd1, 1'b0, 1'b0, 1'b0);
        total++;
        if (obs !== 15'd0) begin
            bad++; $display("[TB] FAIL invalid_slot got=%h exp=%h", obs, 15'd0);
        end
    endtask

    task automatic test_hazard();
        logic [14:0] e;
        applyStimulus(6'd3, 1'b1, 1'b1, 1'b0);
        total++;
        if (obs !== 15'd0) begin
            bad++; $display("[TB] FAIL hazard_bubble got=%h exp=%h", obs, 15'd0);
        end
        applyStimulus(6'd3, 1'b1, 1'b0, 1'b0);
        e = expv(1'b1, 4'd2, 2'd0, 6'b000100, 1'b0, 1'b0);
        total++;
        if (obs !== e) begin
            bad++; $display("[TB] FAIL sub_after_hazard got=%h exp=%h", obs, e);
        end
    endtask

    task automatic test_mul();
        logic [14:0] e_mul_busy;
        logic [14:0] e_mul_done;
        logic [14:0] e_add;
        logic [14:0] exp_tab [5];
        e_mul_busy = expv(1'b1, 4'd12, 2'd0, 6'b000100, 1'b1, 1'b0);
        e_mul_done = expv(1'b1, 4'd12, 2'd0, 6'b000100, 1'b0, 1'b0);
        e_add      = expv(1'b1, 4'd0,  2'd0, 6'b000100, 1'b0, 1'b0);
        exp_tab = '{e_mul_busy, e_mul_busy, e_mul_busy, e_mul_done, e_add};
        applyStimulus(6'd13, 1'b1, 1'b0, 1'b0);
        total++;
        if (obs !== exp_tab[0]) begin
            bad++; $display("[TB] FAIL mul_cycle0 got=%h exp=%h", obs, exp_tab[0]);
        end
        for (int k = 1; k < 5; k++) begin
            applyStimulus(6'd1, 1'b1, (k == 1), 1'b0);
            total++;
            if (obs !== exp_tab[k]) begin
                bad++; $display("[TB] FAIL mul_cycle%0d got=%h exp=%h", k, obs, exp_tab[k]);
            end
        end
    endtask

    task automatic test_flush();
        logic [14:0] e;
        applyStimulus(6'd13, 1'b1, 1'b0, 1'b0);
        applyStimulus(6'd1, 1'b1, 1'b0, 1'b0);
        e = expv(1'b1, 4'd12, 2'd0, 6'b000100, 1'b1, 1'b0);
        total++;
        if (obs !== e) begin
            bad++; $display("[TB] FAIL flush_pre_busy got=%h exp=%h", obs, e);
        end
        applyStimulus(6'd1, 1'b1, 1'b0, 1'b1);
        total++;
        if (obs !== 15'd0) begin
            bad++; $display("[TB] FAIL flush_in_busy got=%h exp=%h", obs, 15'd0);
        end
        applyStimulus(6'd63, 1'b1, 1'b1, 1'b1);
        total++;
        if (obs !== 15'd0) begin
            bad++; $display("[TB] FAIL flush_hazard got=%h exp=%h", obs, 15'd0);
        end
        total++;
        if (obs0 !== 15'd0) begin
            bad++; $display("[TB] FAIL flush_hazard_noext got=%h exp=%h", obs0, 15'd0);
        end
        applyStimulus(6'd1, 1'b1, 1'b0, 1'b0);
        e = expv(1'b1, 4'd0, 2'd0, 6'b000100, 1'b0, 1'b0);
        total++;
        if (obs !== e) begin
            bad++; $display("[TB] FAIL add_after_flush got=%h exp=%h", obs, e);
        end
    endtask

    task automatic test_ext_ops();
        logic [14:0] e;
        logic [14:0] e_ill;
        e_ill = expv(1'b0, 4'd0, 2'd0, 6'b000000, 1'b0, 1'b1);
        applyStimulus(6'd6, 1'b1, 1'b0, 1'b0);
        total++;
        if (obs0 !== e_ill) begin
            bad++; $display("[TB] FAIL or_noext got=%h exp=%h", obs0, e_ill);
        end
        e = expv(1'b1, 4'd5, 2'd0, 6'b000100, 1'b0, 1'b0);
        total++;
        if (obs !== e) begin
            bad++; $display("[TB] FAIL or_ext got=%h exp=%h", obs, e);
        end
        applyStimulus(6'd1, 1'b1, 1'b0, 1'b0);
        e = expv(1'b1, 4'd0, 2'd0, 6'b000100, 1'b0, 1'b0);
        total++;
        if (obs0 !== e) begin
            bad++; $display("[TB] FAIL illegal_pulse_clear got=%h exp=%h", obs0, e);
        end
        applyStimulus(6'd63, 1'b1, 1'b0, 1'b0);
        total++;
        if (obs !== e_ill) begin
            bad++; $display("[TB] FAIL op63_ext got=%h exp=%h", obs, e_ill);
        end
        total++;
        if (obs0 !== e_ill) begin
            bad++; $display("[TB] FAIL op63_noext got=%h exp=%h", obs0, e_ill);
        end
        applyStimulus(6'd42, 1'b1, 1'b0, 1'b0);
        e = expv(1'b1, 4'd15, 2'd2, 6'b110000, 1'b0, 1'b0);
        total++;
        if (obs !== e) begin
            bad++; $display("[TB] FAIL jmp got=%h exp=%h", obs, e);
        end
        total++;
        if (obs0 !== e_ill) begin
            bad++; $display("[TB] FAIL jmp_noext got=%h exp=%h", obs0, e_ill);
        end
        applyStimulus(6'd41, 1'b1, 1'b0, 1'b0);
        e = expv(1'b1, 4'd15, 2'd1, 6'b111000, 1'b0, 1'b0);
        total++;
        if (obs !== e) begin
            bad++; $display("[TB] FAIL bne got=%h exp=%h", obs, e);
        end
        applyStimulus(6'd40, 1'b1, 1'b0, 1'b0);
        e = expv(1'b1, 4'd15, 2'd0, 6'b110000, 1'b0, 1'b0);
        total++;
        if (obs !== e) begin
            bad++; $display("[TB] FAIL bez got=%h exp=%h", obs, e);
        end
        applyStimulus(6'd33, 1'b1, 1'b0, 1'b0);
        e = expv(1'b1, 4'd2, 2'd0, 6'b010100, 1'b0, 1'b0);
        total++;
        if (obs !== e) begin
            bad++; $display("[TB] FAIL subi got=%h exp=%h", obs, e);
        end
        total++;
        if (obs0 !== e_ill) begin
            bad++; $display("[TB] FAIL subi_noext got=%h exp=%h", obs0, e_ill);
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_hazard();
        test_mul();
        test_flush();
        test_ext_ops();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/id_ctrl_stage.md
Name: id_ctrl_stage

Overview:
- Parametrised decode-stage controller for the 5-stage pipeline.
- Decodes the opcode into the execute/memory/writeback control bundle and registers it into the ID/EXE pipeline register.
- Inserts bubbles on load-use hazard, flush and illegal opcodes.
- Sequences multi-cycle MUL operations with a busy FSM that raises a stall request to fetch/decode.

Parameters:
- OP_W, 6, opcode width.
- EXE_W, 4, execute-command width.
- MUL_CYCLES, 4, total execute cycles of MUL (1..15); 1 disables the busy FSM.
- EXT_EN, 1, when 1 decodes OR/NOR/XOR/SLA/SRA/SRL/SUBI/BEZ/JMP; when 0 those are illegal.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- op_code  in  OP_W  opcode of the instruction in ID.
- instr_valid  in  1  ID holds a real instruction.
- hazard_detected  in  1  load-use hazard; bubble into EXE this cycle.
- flush  in  1  taken branch; kill ID instruction and abort MUL.
- ex_valid  out  1  EXE slot holds a real instruction.
- ex_exe_cmd  out  EXE_W  ALU command.
- ex_branch_cmd  out  2  branch condition.
- ex_branch_en, ex_is_imm, ex_st_or_bne, ex_wb_en, ex_mem_r_en, ex_mem_w_en  out  1 each  control bits.
- stall_req  out  1  hold PC and IF/ID (MUL busy).
- illegal_op  out  1  one-cycle pulse, registered.

Behaviour:
- Reset (rst=0, async): every output 0; FSM IDLE; counter 0.
- Decode is combinational from op_code. Encodings come from the package:
  - ADD/SUB/AND/OR/NOR/XOR/SLA/SLL/SRA/SRL/MUL: matching EXE cmd, wb_en.
  - ADDI/SUBI: EXE_ADD/EXE_SUB, wb_en, is_imm.
  - LD: EXE_ADD, wb_en, is_imm, st_or_bne, mem_r_en.
  - ST: EXE_ADD, is_imm, st_or_bne, mem_w_en.
  - BNE: EXE_NOP, is_imm, st_or_bne, branch_en, COND_BNE.
  - BEZ: EXE_NOP, is_imm, branch_en, COND_BEZ.
  - JMP: EXE_NOP, is_imm, branch_en, COND_JUMP.
  - NOP: all-zero bundle with ex_valid=1.
  - Unlisted opcodes, or extended ops with EXT_EN=0: illegal.
- Bubble means all ex_* control bits 0 and ex_valid=0.
- Registered update each rising edge, first match wins:
  1. flush → bubble; FSM→IDLE; counter→0.
  2. FSM BUSY → ex_* held unchanged; counter decrements.
  3. hazard_detected → bubble.
  4. instr_valid=0 → bubble.
  5. Illegal opcode → bubble; illegal_op=1 for that cycle.
  6. Otherwise → load the decoded bundle with ex_valid=1.
- illegal_op is 0 on every cycle without an illegal load.
- MUL FSM states:
  - IDLE → BUSY when MUL is loaded (case 6) and MUL_CYCLES>1; counter loads MUL_CYCLES-1.
  - BUSY → IDLE on the edge where counter==1 (counter→0), or on flush.
- stall_req = (state==BUSY), decoded from the state register, no combinational input path. With MUL_CYCLES=N it is high exactly N-1 cycles after the MUL accept edge.
- ID inputs are ignored while BUSY, because upstream is stalled.
- hazard_detected asserted while BUSY is ignored; the hold wins.
- Flush and hazard together: flush wins.
- MUL followed immediately by MUL: the second is accepted on the cycle after stall_req falls.
- Reset mid-MUL: immediate return to IDLE; stall_req drops asynchronously.
- Latency: decode to ex_* is 1 cycle. No path from op_code to any output is combinational.

Decomposition:
- Shared package pipe_defs holds:
  - OP_W default.
  - All OP_* encodings: NOP=0, ADD=1, SUB=3, AND=5, OR=6, NOR=7, XOR=8, SLA=9, SLL=10, SRA=11, SRL=12, MUL=13, ADDI=32, SUBI=33, LD=36, ST=37, BEZ=40, BNE=41, JMP=42.
  - EXE_* codes: ADD=0, SUB=2, AND=4, OR=5, NOR=6, XOR=7, SLA=8, SLL=8, SRA=9, SRL=10, MUL=12, NOP=15.
  - COND_*: BEZ=0, BNE=1, JUMP=2.
  - Control-bundle struct type.
- One sub-module: id_ctrl_decode, purely combinational, mapping opcode to {bundle, illegal}. The top holds the register, priority mux and MUL FSM.

Test Plan:
- Reset: rst=0 mid-run → all outputs 0 immediately. Release, op=ADD(1), valid=1 → next edge ex_exe_cmd=0, ex_wb_en=1, ex_valid=1.
- LD(36) then ST(37) back-to-back:
  - LD → mem_r_en=1, wb_en=1, is_imm=1, st_or_bne=1.
  - ST → mem_w_en=1, wb_en=0, st_or_bne=1.
- Hazard: op=SUB with hazard_detected=1 → bubble (ex_valid=0, wb_en=0). Next cycle without hazard → ex_exe_cmd=2, wb_en=1.
- MUL with MUL_CYCLES=4: op=13 → ex_exe_cmd=12 held 4 cycles; stall_req=1 for exactly 3 cycles. A following ADD is loaded on the cycle stall_req=0.
- Flush during BUSY (2nd stall cycle) → bubble next edge, stall_req=0, FSM IDLE. Hazard and flush together → bubble, no illegal_op.
- EXT_EN=0, op=OR(6) → bubble, illegal_op=1 for one cycle. op=63 → same. EXT_EN=1, op=JMP(42) → branch_en=1, branch_cmd=2, exe_cmd=15.
